msg_schedule: RTL
=================

// Module: msg_schedule
// PURPOSE
//  Dual-mode message scheduler for the hashing module; successor to the fixed SHA-1 expander.
//  Loads one 512-bit block and streams the schedule words W[t] one per handshake:
//   - SHA-1: 80 words
//   - SHA-256: 64 words
//  Uses a 16-entry circular window, not an 80-word array. Feeds the round/compression core.
// PARAMETERS
//  SHA1_ROUNDS  80  words emitted in SHA-1 mode
//  SHA2_ROUNDS  64  words emitted in SHA-256 mode
//  IDX_W        7   width of w_idx/round counter; must hold max(rounds)-1
// PORTS
//  clk      in   1    system clock, rising edge
//  rst      in   1    synchronous, active-high reset
//  start    in   1    load blk_in and begin; sampled only in IDLE
//  mode     in   1    0 = SHA-1, 1 = SHA-256; latched with start
//  blk_in   in   512  message block; blk_in[511:480] = W0 ... blk_in[31:0] = W15
//  busy     out  1    high from accepted start until done pulse inclusive
//  w_valid  out  1    w_out/w_idx hold a valid schedule word
//  w_ready  in   1    consumer accepts w_out this cycle
//  w_out    out  32   schedule word W[w_idx]
//  w_idx    out  7    round index t of w_out
//  done     out  1    one-cycle pulse after last word accepted
// BEHAVIOUR
//  Clock and reset:
//   - One clock. Reset is synchronous and active-high.
//   - On rst: state=IDLE, t=0, busy=0, w_valid=0, done=0, w_out=0, w_idx=0, window cleared.
//   - rst mid-block aborts: no done pulse; next start behaves as a fresh block.
//  States:
//   - IDLE: start=1 -> latch mode; window[i] <= blk_in word i; t <= 0; go EMIT.
//     busy and w_valid rise the cycle after start.
//   - EMIT: w_valid=1. Handshake = w_valid & w_ready.
//       On handshake with t < N-1: store new word, t <= t+1.
//       On handshake with t == N-1: go DONE. N = SHA1_ROUNDS or SHA2_ROUNDS per latched mode.
//   - DONE: done=1, busy=1, w_valid=0 for exactly one cycle; then IDLE.
//  Word generation:
//   - Registered output; combinational next-word logic from the window; slot = t mod 16.
//   - t < 16: W[t] = window[t].
//   - t >= 16, SHA-1:   W[t] = rotl1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]).
//   - t >= 16, SHA-256: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32 (carry dropped).
//       s0(x) = rotr7 ^ rotr18 ^ shr3
//       s1(x) = rotr17 ^ rotr19 ^ shr10
//   - Computed W[t] is written to window[t mod 16] when emitted, overwriting W[t-16]; window index wraps 15->0.
//  Handshake rules:
//   - Zero-bubble: with w_ready held high, one word per cycle; first word appears 1 cycle after start.
//   - Backpressure: while w_valid & !w_ready, w_out, w_idx and the window hold stable; no word is dropped or recomputed differently.
//   - start while busy is ignored.
//   - start in the DONE cycle is ignored; it is accepted only in IDLE.
//   - mode/blk_in changes after acceptance have no effect until the next start.
//   - Output words are a pure function of the latched block and mode, independent of stall pattern.
// TESTING
//  1. SHA-1, "abc" padded block (W0=0x61626380, W15=0x00000018, else 0), w_ready=1
//     -> W0 one cycle after start; W16=0xC2C4C700; 80 words then done pulse; busy low next cycle.
//  2. SHA-256, same block, w_ready=1 -> W16=0x61626380, W17=0x000F0000; exactly 64 words (w_idx 0..63) then done.
//  3. Backpressure: SHA-256, w_ready toggled pseudo-randomly
//     -> stable w_out/w_idx during stalls; word stream identical to scenario 2.
//  4. start pulsed mid-stream with a different blk_in and mode -> ignored; current stream completes unchanged.
//  5. rst asserted at w_idx=40 (SHA-1) -> all outputs 0 next cycle, no done.
//     Fresh start then reproduces scenario 1 exactly.
//  6. Back-to-back blocks: start asserted the cycle after done
//     -> accepted; second block's W0 emitted one cycle later, index restarts at 0.

Source files
------------

// File: rtl/msg_schedule.sv
// Dual-mode (SHA-1 / SHA-256) message schedule generator.
// Streams W[t] one word per valid/ready handshake from a 16-word circular window.
module msg_schedule #(
    parameter int SHA1_ROUNDS = 80,
    parameter int SHA2_ROUNDS = 64,
    parameter int IDX_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [511:0]     blk_in,
    output logic             busy,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_out,
    output logic [IDX_W-1:0] w_idx,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_SHA1 = IDX_W'(SHA1_ROUNDS - 1);
    localparam logic [IDX_W-1:0] LAST_SHA2 = IDX_W'(SHA2_ROUNDS - 1);

    state_t            state_reg;
    logic              mode_reg;
    logic [31:0]       window_reg [16];
    logic [31:0]       blk_word [16];

    logic [IDX_W-1:0]  t_next;
    logic [3:0]        slot_next;
    logic [31:0]       sha1_word;
    logic [31:0]       sha2_word;
    logic [31:0]       word_next;
    logic              last_word;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_blk_split
            assign blk_word[gi] = blk_in[511 - 32*gi -: 32];
        end
    endgenerate

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // While W[t] is on the output, the window holds W[t-15..t], so W[t+1]
    // can be built from it; the slot of W[t+1-16] is the one it replaces.
    always_comb begin
        t_next    = w_idx + IDX_W'(1);
        slot_next = t_next[3:0];
        sha1_word = window_reg[slot_next - 4'd3] ^ window_reg[slot_next - 4'd8]
                  ^ window_reg[slot_next - 4'd14] ^ window_reg[slot_next];
        sha1_word = {sha1_word[30:0], sha1_word[31]};
        sha2_word = sig1(window_reg[slot_next - 4'd2]) + window_reg[slot_next - 4'd7]
                  + sig0(window_reg[slot_next - 4'd15]) + window_reg[slot_next];
        if (t_next < IDX_W'(16))
            word_next = window_reg[slot_next];
        else
            word_next = mode_reg ? sha2_word : sha1_word;
        last_word = (w_idx == (mode_reg ? LAST_SHA2 : LAST_SHA1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= 1'b0;
            busy      <= 1'b0;
            w_valid   <= 1'b0;
            done      <= 1'b0;
            w_out     <= '0;
            w_idx     <= '0;
            for (int i = 0; i < 16; i++)
                window_reg[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_reg <= mode;
                        for (int i = 0; i < 16; i++)
                            window_reg[i] <= blk_word[i];
                        w_out     <= blk_word[0];
                        w_idx     <= '0;
                        w_valid   <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_ready) begin
                        if (last_word) begin
                            w_valid   <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            w_out                 <= word_next;
                            w_idx                 <= t_next;
                            window_reg[slot_next] <= word_next;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
